// File: rtl/divide5_seq.sv
`default_nettype none
// ============================================================================
// Module   : divide5_seq
// Brief    : Bit-serial restoring divide-by-5 of a 7-bit operand with
//            start/busy/done handshake. Optional `exact` flag via DIV5_EXACT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module divide5_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] X,
    output logic       busy,
    output logic       done,
    output logic [4:0] Q,
    output logic [2:0] R
`ifdef DIV5_EXACT_EN
    ,
    output logic       exact
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [6:0]  dividend;
    logic [2:0]  prem;       // partial remainder never reaches 5, so bit 3 is always 0
    logic [4:0]  quot;       // upper quotient bits are provably 0 (X <= 127 -> Q <= 25)
    logic [2:0]  bit_cnt;

    logic [3:0]  trial;
    logic        ge5;
    logic [2:0]  prem_nx;
    logic [4:0]  quot_nx;

    always_comb begin
        trial   = {prem, dividend[6]};
        ge5     = (trial >= 4'd5);
        prem_nx = ge5 ? 3'(trial - 4'd5) : trial[2:0];
        quot_nx = {quot[3:0], ge5};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (bit_cnt == 3'd0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dividend <= 7'd0;
            prem     <= 3'd0;
            quot     <= 5'd0;
            bit_cnt  <= 3'd0;
            Q        <= 5'd0;
            R        <= 3'd0;
`ifdef DIV5_EXACT_EN
            exact    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dividend <= X;
                        prem     <= 3'd0;
                        quot     <= 5'd0;
                        bit_cnt  <= 3'd6;
                    end
                end
                S_RUN: begin
                    dividend <= {dividend[5:0], 1'b0};
                    prem     <= prem_nx;
                    quot     <= quot_nx;
                    bit_cnt  <= bit_cnt - 3'd1;
                    // Final iteration: publish the freshly computed bit with the rest
                    if (bit_cnt == 3'd0) begin
                        Q <= quot_nx;
                        R <= prem_nx;
`ifdef DIV5_EXACT_EN
                        exact <= (prem_nx == 3'd0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_divide5_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_divide5_seq
// Brief    : Scoreboard bench for divide5_seq: driver queues expected results,
//            a negedge monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divide5_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] X;
    logic       busy;
    logic       done;
    logic [4:0] Q;
    logic [2:0] R;
    logic       exact;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int x;
        int q;
        int r;
        int due;
    } exp_t;

    exp_t sb[$];

    divide5_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .X     (X),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R)
`ifdef DIV5_EXACT_EN
        ,
        .exact (exact)
`endif
    );

`ifndef DIV5_EXACT_EN
    assign exact = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Monitor: handshake sanity every cycle, result check on every done pulse
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap busy=%0b done=%0b required not both high", busy, done);
        end
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_done Q=%0d R=%0d with no operation outstanding", Q, R);
            end else begin
                e = sb.pop_front();
                if (Q !== 5'(e.q) || R !== 3'(e.r) || cyc != e.due) begin
                    errors++;
                    $display("FAIL result X=%0d got Q=%0d R=%0d cycle=%0d required Q=%0d R=%0d cycle=%0d",
                             e.x, Q, R, cyc, e.q, e.r, e.due);
                end
`ifdef DIV5_EXACT_EN
                checks++;
                if (exact !== (e.r == 0)) begin
                    errors++;
                    $display("FAIL exact X=%0d got %0b required %0b", e.x, exact, (e.r == 0));
                end
`endif
            end
        end
    end

    task automatic push_exp(input int x, input int q, input int r);
        exp_t e;
        e.x   = x;
        e.q   = q;
        e.r   = r;
        e.due = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done || reset) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input int x, input int q, input int r);
        wait_idle();
        X     = 7'(x);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(x, q, r);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout outstanding=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Q !== 5'd0 || R !== 3'd0 || exact !== 1'b0) begin
            errors++;
            $display("FAIL %s busy=%0b done=%0b Q=%0d R=%0d exact=%0b required all 0",
                     name, busy, done, Q, R, exact);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        X     = 7'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        issue(0, 0, 0);     wait_drain(20);
        issue(127, 25, 2);  wait_drain(20);
        issue(64, 12, 4);   wait_drain(20);
        issue(5, 1, 0);     wait_drain(20);

        // start during RUN must be ignored and not queued
        issue(23, 4, 3);
        repeat (2) @(negedge clk);
        X     = 7'd99;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_drain(20);
        repeat (12) @(negedge clk);
        checks++;
        if (Q !== 5'd4 || R !== 3'd3) begin
            errors++;
            $display("FAIL ignored_start got Q=%0d R=%0d required Q=4 R=3", Q, R);
        end

        // abort mid-division with asynchronous reset
        issue(100, 20, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        issue(100, 20, 0);  wait_drain(20);

        // start held high: X re-sampled on each accept, 9-cycle spacing
        wait_idle();
        X     = 7'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, 0, 0);
        for (int i = 1; i < 128; i++) begin
            X = 7'(i);
            repeat (9) @(posedge clk);
            #1;
            push_exp(i, i / 5, i % 5);
        end
        start = 1'b0;
        wait_drain(30);

        // round trip through the x5 datapath
        for (int a = 0; a < 16; a++) begin
            issue((a << 2) + a, a, 0);
            wait_drain(20);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
